// File: rtl/colour_pkg.sv
// ---------------------------------------------------------------------------
// colour_pkg
// Shared definitions for the colour converter scheduler slice.
//   - sched_state_e : scheduler FSM state encoding
//   - RGB_W, CODE_W : widths of the RGB result and the colour code
//   - BLACK..WHITE  : 3-bit colour codes, with matching RGB_* 24-bit values
//   - code_to_rgb   : expected converter output for a given colour code
// ---------------------------------------------------------------------------
package colour_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

   localparam int RGB_W  = 24;
   localparam int CODE_W = 3;

   localparam logic [CODE_W-1:0] BLACK   = 3'd0;
   localparam logic [CODE_W-1:0] BLUE    = 3'd1;
   localparam logic [CODE_W-1:0] GREEN   = 3'd2;
   localparam logic [CODE_W-1:0] CYAN    = 3'd3;
   localparam logic [CODE_W-1:0] RED     = 3'd4;
   localparam logic [CODE_W-1:0] MAGENTA = 3'd5;
   localparam logic [CODE_W-1:0] YELLOW  = 3'd6;
   localparam logic [CODE_W-1:0] WHITE   = 3'd7;

   localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;
   localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
   localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
   localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
   localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
   localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
   localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
   localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;

   // Each code bit selects a full-intensity byte: bit2 red, bit1 green,
   // bit0 blue. Written as a lookup so the named colours stay the single
   // source of truth for what the converter is expected to produce.
   function automatic logic [RGB_W-1:0] code_to_rgb(input logic [CODE_W-1:0] code);
      logic [RGB_W-1:0] rgb;
      case (code)
         BLACK:   rgb = RGB_BLACK;
         BLUE:    rgb = RGB_BLUE;
         GREEN:   rgb = RGB_GREEN;
         CYAN:    rgb = RGB_CYAN;
         RED:     rgb = RGB_RED;
         MAGENTA: rgb = RGB_MAGENTA;
         YELLOW:  rgb = RGB_YELLOW;
         default: rgb = RGB_WHITE;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection. The search starts one
// position after ptr and wraps, so the most recently served requester has
// the lowest priority. The pointer register lives in the parent.
// Ports:
//   req      in  NREQ  request vector
//   ptr      in  IDW   index of the requester served last
//   grant    out NREQ  one-hot grant (all zero when no request)
//   grant_id out IDW   index of the granted requester
//   any      out 1     at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            any
);

   int idx;

   // Walk the requesters in priority order (ptr+1, ptr+2, ... wrapping) and
   // take the first one found; later hits are ignored once any is set.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = 0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = (int'(ptr) + off) % NREQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/colour_sched.sv
// ---------------------------------------------------------------------------
// colour_sched
// Round-robin scheduler sharing a single colour_conv instance among NREQ
// requesters. A grant latches the requester's colour code, pulses the
// converter enable for one cycle, waits CONV_LAT cycles, captures the RGB
// result and returns it with a one-cycle ack to the granted requester.
// Optional build macro: COLOUR_SCHED_CHECK_EN adds a sticky err output that
// flags a converter result differing from the expected RGB for the code.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req          per-requester request, held until ack
//   req_colour   requester i colour code at [3i+2:3i]
//   ack          one-hot, one-cycle ack to the served requester
//   rgb_out      captured converter result (held until next capture)
//   rgb_valid    one-cycle strobe alongside ack
//   rgb_id       index of the served requester
//   busy         high whenever the FSM is not idle
//   conv_enable  converter enable (one cycle per transaction)
//   conv_colour  colour code driven to the converter
//   conv_rgb     converter RGB output
//   err          (COLOUR_SCHED_CHECK_EN only) sticky converter mismatch
// ---------------------------------------------------------------------------
module colour_sched
   import colour_pkg::*;
#(
   parameter  int NREQ     = 4,
   parameter  int CONV_LAT = 1,
   localparam int IDW      = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [CODE_W*NREQ-1:0] req_colour,
   output logic [NREQ-1:0]        ack,
   output logic [RGB_W-1:0]       rgb_out,
   output logic                   rgb_valid,
   output logic [IDW-1:0]         rgb_id,
   output logic                   busy,
   output logic                   conv_enable,
   output logic [CODE_W-1:0]      conv_colour,
   input  logic [RGB_W-1:0]       conv_rgb
`ifdef COLOUR_SCHED_CHECK_EN
   ,
   output logic                   err
`endif
);

   localparam int              CNT_W    = $clog2(CONV_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_LAT - 1);
   localparam logic [IDW-1:0]   PTR_INIT = IDW'(NREQ - 1);

   sched_state_e      state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    grant_id_q, grant_id_d;
   logic [NREQ-1:0]   grant_oh_q, grant_oh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] conv_colour_q, conv_colour_d;
   logic              conv_enable_q, conv_enable_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              rgb_valid_q, rgb_valid_d;
   logic [RGB_W-1:0]  rgb_out_q, rgb_out_d;
   logic [IDW-1:0]    rgb_id_q, rgb_id_d;
   logic              busy_q, busy_d;
`ifdef COLOUR_SCHED_CHECK_EN
   logic              err_q, err_d;
`endif

   logic [NREQ-1:0]   arb_grant;
   logic [IDW-1:0]    arb_id;
   logic              arb_any;
   logic [CODE_W-1:0] arb_colour;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req      (req),
      .ptr      (ptr_q),
      .grant    (arb_grant),
      .grant_id (arb_id),
      .any      (arb_any)
   );

   // Colour code of whichever requester the arbiter is currently pointing at.
   always_comb begin
      arb_colour = req_colour[CODE_W*int'(arb_id) +: CODE_W];
   end

   // Next-state logic. All outputs are registered, so each value computed
   // here becomes visible during the state being entered: the enable shows
   // up during ISSUE and ack/rgb_valid during DONE. The pointer only moves
   // in DONE, so a transaction killed by reset leaves priority unchanged.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      grant_oh_d    = grant_oh_q;
      cnt_d         = cnt_q;
      conv_colour_d = conv_colour_q;
      conv_enable_d = 1'b0;
      ack_d         = '0;
      rgb_valid_d   = 1'b0;
      rgb_out_d     = rgb_out_q;
      rgb_id_d      = rgb_id_q;
`ifdef COLOUR_SCHED_CHECK_EN
      err_d         = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_id_d    = arb_id;
               grant_oh_d    = arb_grant;
               conv_colour_d = arb_colour;
               conv_enable_d = 1'b1;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               rgb_out_d   = conv_rgb;
               rgb_id_d    = grant_id_q;
               ack_d       = grant_oh_q;
               rgb_valid_d = 1'b1;
               state_d     = ST_DONE;
`ifdef COLOUR_SCHED_CHECK_EN
               if (conv_rgb != code_to_rgb(conv_colour_q)) begin
                  err_d = 1'b1;
               end
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            ptr_d   = grant_id_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Single register bank for the FSM and every output. Reset drops any
   // in-flight transaction and points priority at requester NREQ-1 so that
   // requester 0 wins the first arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= PTR_INIT;
         grant_id_q    <= '0;
         grant_oh_q    <= '0;
         cnt_q         <= '0;
         conv_colour_q <= '0;
         conv_enable_q <= 1'b0;
         ack_q         <= '0;
         rgb_valid_q   <= 1'b0;
         rgb_out_q     <= '0;
         rgb_id_q      <= '0;
         busy_q        <= 1'b0;
`ifdef COLOUR_SCHED_CHECK_EN
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         grant_oh_q    <= grant_oh_d;
         cnt_q         <= cnt_d;
         conv_colour_q <= conv_colour_d;
         conv_enable_q <= conv_enable_d;
         ack_q         <= ack_d;
         rgb_valid_q   <= rgb_valid_d;
         rgb_out_q     <= rgb_out_d;
         rgb_id_q      <= rgb_id_d;
         busy_q        <= busy_d;
`ifdef COLOUR_SCHED_CHECK_EN
         err_q         <= err_d;
`endif
      end
   end

   assign ack         = ack_q;
   assign rgb_out     = rgb_out_q;
   assign rgb_valid   = rgb_valid_q;
   assign rgb_id      = rgb_id_q;
   assign busy        = busy_q;
   assign conv_enable = conv_enable_q;
   assign conv_colour = conv_colour_q;
`ifdef COLOUR_SCHED_CHECK_EN
   assign err         = err_q;
`endif

endmodule

// File: tb/tb_colour_sched.sv
// ---------------------------------------------------------------------------
// tb_colour_sched
// Self-checking bench for colour_sched. A behavioural converter drives
// conv_rgb; a cycle-count reference model predicts every grant, ack and
// captured result from the round-robin and latency rules.
// ---------------------------------------------------------------------------
module tb_colour_sched;
   import colour_pkg::*;

   parameter  int CONV_LAT = 1;
   localparam int NREQ     = 4;
   localparam int IDW      = $clog2(NREQ);

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [NREQ-1:0]        req;
   logic [CODE_W*NREQ-1:0] req_colour;
   logic [NREQ-1:0]        ack;
   logic [RGB_W-1:0]       rgb_out;
   logic                   rgb_valid;
   logic [IDW-1:0]         rgb_id;
   logic                   busy;
   logic                   conv_enable;
   logic [CODE_W-1:0]      conv_colour;
   logic [RGB_W-1:0]       conv_rgb;
`ifdef COLOUR_SCHED_CHECK_EN
   logic                   err;
`endif

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state, in clock-edge counts.
   int          edgeCnt   = 0;
   int          evalEdge  = 1;
   int          grantEdge = -100;
   int          ackEdge   = -100;
   bit          inFlight  = 1'b0;
   int          modelPtr  = NREQ - 1;
   int          expId     = 0;
   logic [2:0]  expCode   = '0;
   logic [23:0] txnMask   = '0;
   logic [23:0] lastRgb   = '0;
   int          lastId    = 0;
   bit          expErr    = 1'b0;
   bit          autoDrop  = 1'b1;
   int          pendCnt [NREQ];

   logic [23:0] corruptMask = '0;
   logic [23:0] convPipe [CONV_LAT];

   colour_sched #(
      .NREQ     (NREQ),
      .CONV_LAT (CONV_LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_colour  (req_colour),
      .ack         (ack),
      .rgb_out     (rgb_out),
      .rgb_valid   (rgb_valid),
      .rgb_id      (rgb_id),
      .busy        (busy),
      .conv_enable (conv_enable),
      .conv_colour (conv_colour),
      .conv_rgb    (conv_rgb)
`ifdef COLOUR_SCHED_CHECK_EN
      ,
      .err         (err)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural converter: samples the code while enable is high and
   // presents the result CONV_LAT clocks later. corruptMask lets the bench
   // inject a wrong converter answer.
   always @(posedge clk) begin
      if (conv_enable) begin
         convPipe[0] <= code_to_rgb(conv_colour) ^ corruptMask;
      end
      for (int i = 1; i < CONV_LAT; i++) begin
         convPipe[i] <= convPipe[i-1];
      end
   end
   assign conv_rgb = convPipe[CONV_LAT-1];

   // Expected RGB by plain arithmetic: every set code bit adds a full byte.
   function automatic logic [23:0] expandCode(input logic [2:0] code);
      logic [23:0] r;
      r = '0;
      for (int b = 0; b < 3; b++) begin
         if (code[b]) r = r + (24'hFF << (8 * b));
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edgeCnt);
      end
   endtask

   task automatic applyStimulus(input int i, input bit on, input logic [2:0] code);
      req[i] = on;
      req_colour[3*i +: 3] = code;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".ack"}, 32'(ack), 32'h0);
      checkOutput({tag, ".rgb_valid"}, 32'(rgb_valid), 32'h0);
      checkOutput({tag, ".rgb_out"}, 32'(rgb_out), 32'h0);
      checkOutput({tag, ".rgb_id"}, 32'(rgb_id), 32'h0);
      checkOutput({tag, ".conv_enable"}, 32'(conv_enable), 32'h0);
      checkOutput({tag, ".conv_colour"}, 32'(conv_colour), 32'h0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
`ifdef COLOUR_SCHED_CHECK_EN
      checkOutput({tag, ".err"}, 32'(err), 32'h0);
`endif
   endtask

   task automatic doReset(input string tag);
      rst = 1'b1;
      #1;
      checkResetOutputs(tag);
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput({tag, ".ackInReset"}, 32'(ack), 32'h0);
      end
      rst = 1'b0;
      inFlight = 1'b0;
      modelPtr = NREQ - 1;
      evalEdge = edgeCnt + 1;
      lastRgb  = '0;
      lastId   = 0;
      expErr   = 1'b0;
      for (int i = 0; i < NREQ; i++) pendCnt[i] = 0;
   endtask

   // One clock: advance the model, compare every output, then let requesters
   // drop the request that has just been acknowledged.
   task automatic stepCycle();
      logic [NREQ-1:0] expAck;
      bit found;
      bit ackNow;
      int idx;
      @(posedge clk);
      #1;
      edgeCnt++;
      found = 1'b0;
      if (edgeCnt == evalEdge) begin
         if (req != '0) begin
            for (int off = 1; off <= NREQ; off++) begin
               idx = (modelPtr + off) % NREQ;
               if (!found && req[idx]) begin
                  found = 1'b1;
                  expId = idx;
               end
            end
            expCode   = req_colour[3*expId +: 3];
            txnMask   = corruptMask;
            grantEdge = edgeCnt;
            ackEdge   = edgeCnt + 1 + CONV_LAT;
            evalEdge  = ackEdge + 2;
            inFlight  = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
               if (i == expId || !req[i]) begin
                  pendCnt[i] = 0;
               end else begin
                  pendCnt[i]++;
                  checkOutput("fairness", 32'(pendCnt[i] <= NREQ - 1), 32'h1);
               end
            end
         end else begin
            evalEdge = edgeCnt + 1;
         end
      end
      ackNow = inFlight && (edgeCnt == ackEdge);
      expAck = '0;
      if (ackNow) begin
         expAck[expId] = 1'b1;
         lastRgb = expandCode(expCode) ^ txnMask;
         lastId  = expId;
         if (txnMask != '0) expErr = 1'b1;
      end
      checkOutput("ack", 32'(ack), 32'(expAck));
      checkOutput("rgb_valid", 32'(rgb_valid), 32'(ackNow));
      checkOutput("rgb_out", 32'(rgb_out), 32'(lastRgb));
      checkOutput("rgb_id", 32'(rgb_id), 32'(lastId));
      checkOutput("conv_enable", 32'(conv_enable), 32'(inFlight && edgeCnt == grantEdge));
      checkOutput("busy", 32'(busy), 32'(inFlight && edgeCnt >= grantEdge && edgeCnt <= ackEdge));
      if (inFlight) checkOutput("conv_colour", 32'(conv_colour), 32'(expCode));
`ifdef COLOUR_SCHED_CHECK_EN
      checkOutput("err", 32'(err), 32'(expErr));
`endif
      if (ackNow) begin
         modelPtr = expId;
         inFlight = 1'b0;
         if (autoDrop) req[expId] = 1'b0;
      end
   endtask

   task automatic waitAck(input string tag, output int n);
      bit got;
      got = 1'b0;
      n = 0;
      while (!got && n < 60) begin
         stepCycle();
         n++;
         if (ack != '0) got = 1'b1;
      end
      checkOutput({tag, ".ackSeen"}, 32'(got), 32'h1);
   endtask

   task automatic drain();
      int n;
      req = '0;
      n = 0;
      do begin
         stepCycle();
         n++;
      end while (busy && n < 60);
      checkOutput("drainIdle", 32'(busy), 32'h0);
      stepCycle();
   endtask

   initial begin
      int n;
      int ids [5];
      logic [23:0] rgbs [5];
      int gaps [5];
      int expIds [5];
      logic [23:0] expRgbs [5];
      expIds  = '{0, 1, 2, 3, 0};
      expRgbs = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h0000FF};

      req = '0;
      req_colour = '0;
      for (int i = 0; i < NREQ; i++) pendCnt[i] = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      doReset("reset");

      $display("[TB] single requester 2, code 110");
      applyStimulus(2, 1'b1, 3'b110);
      waitAck("single", n);
      checkOutput("single.latency", 32'(n), 32'(2 + CONV_LAT));
      checkOutput("single.rgb", 32'(rgb_out), 32'h00FFFF00);
      checkOutput("single.id", 32'(rgb_id), 32'h2);
      checkOutput("single.ackbit", 32'(ack), 32'h4);
      drain();

      $display("[TB] all four requesters held, codes 1,2,4,7");
      doReset("reset2");
      autoDrop = 1'b0;
      applyStimulus(0, 1'b1, 3'd1);
      applyStimulus(1, 1'b1, 3'd2);
      applyStimulus(2, 1'b1, 3'd4);
      applyStimulus(3, 1'b1, 3'd7);
      for (int k = 0; k < 5; k++) begin
         waitAck("rr", n);
         ids[k]  = int'(rgb_id);
         rgbs[k] = rgb_out;
         gaps[k] = n;
      end
      autoDrop = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checkOutput("rr.id", 32'(ids[k]), 32'(expIds[k]));
         checkOutput("rr.rgb", 32'(rgbs[k]), 32'(expRgbs[k]));
         checkOutput("rr.period", 32'(gaps[k]), 32'((k == 0) ? (2 + CONV_LAT) : (3 + CONV_LAT)));
      end
      drain();

      $display("[TB] colour change after grant is ignored");
      applyStimulus(1, 1'b1, 3'b001);
      stepCycle();
      checkOutput("latch.enable", 32'(conv_enable), 32'h1);
      req_colour[5:3] = 3'b111;
      waitAck("latch", n);
      checkOutput("latch.rgb", 32'(rgb_out), 32'h000000FF);
      drain();

      $display("[TB] reset in the middle of a transaction");
      applyStimulus(0, 1'b1, 3'b101);
      stepCycle();
      stepCycle();
      checkOutput("midreset.busyBefore", 32'(busy), 32'h1);
      doReset("midreset");
      waitAck("midreset", n);
      checkOutput("midreset.id", 32'(rgb_id), 32'h0);
      checkOutput("midreset.rgb", 32'(rgb_out), 32'h00FF00FF);
      drain();

      $display("[TB] randomized traffic");
      for (int c = 0; c < 600; c++) begin
         stepCycle();
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
               if ($urandom_range(3) == 0) applyStimulus(i, 1'b1, 3'($urandom_range(7)));
            end else begin
               n = int'($urandom_range(31));
               if (n == 0) req[i] = 1'b0;
               else if (n < 3) req_colour[3*i +: 3] = 3'($urandom_range(7));
            end
         end
      end
      drain();

`ifdef COLOUR_SCHED_CHECK_EN
      $display("[TB] converter mismatch sets err");
      doReset("chkreset");
      corruptMask = 24'h000001;
      applyStimulus(0, 1'b1, 3'd0);
      waitAck("chk", n);
      checkOutput("chk.err", 32'(err), 32'h1);
      checkOutput("chk.rgb", 32'(rgb_out), 32'h00000001);
      corruptMask = '0;
      applyStimulus(1, 1'b1, 3'd2);
      waitAck("chk2", n);
      checkOutput("chk.sticky", 32'(err), 32'h1);
      drain();
      doReset("chkclear");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
